recirc_merge: RTL and testbench
===============================

Name: recirc_merge

Overview:
- Return-side counterpart of the 4-lane recirculation demux. It merges the main 4-lane byte stream with the words that were diverted to the tester (probador) path and are now coming back, and produces one registered 4-lane output stream toward the mux stage.
- Main traffic always has priority. Returned words wait in a shared word FIFO and are re-injected into idle main cycles.

Parameters:
- DATA_WIDTH, 8, width of each lane.
- DEPTH, 4, recirculation FIFO depth in 4-lane words; must be a power of 2, at least 2.
- CNT_W, $clog2(DEPTH+1), width of fifo_count.

Ports:
- clk  input  1  single clock, all state on the rising edge.
- reset_L  input  1  asynchronous active-low reset.
- main_in0..main_in3  input  DATA_WIDTH each  main-path lane data.
- valid_main  input  1  main word valid, shared by all 4 lanes.
- recirc_in0..recirc_in3  input  DATA_WIDTH each  returned (probador-side) lane data.
- valid_recirc  input  1  returned word valid, shared by all 4 lanes.
- data_out0..data_out3  output  DATA_WIDTH each  merged lane data, registered.
- valid_out  output  1  data_out0..3 hold a valid word.
- src_out  output  1  source of the current output word: 0 = main, 1 = recirculated.
- fifo_count  output  CNT_W  words currently stored in the FIFO.
- fifo_full  output  1  fifo_count == DEPTH.
- fifo_empty  output  1  fifo_count == 0.
- overflow  output  1  sticky flag: a returned word was dropped.

Behaviour:
- Reset (reset_L low, asynchronous, takes effect immediately):
  - data_out0..3 = 0, valid_out = 0, src_out = 0.
  - fifo_count = 0, fifo_empty = 1, fifo_full = 0, overflow = 0.
  - FIFO read and write pointers = 0.
- Reset asserted mid-operation discards all FIFO contents. There is no recovery of stored words.
- All outputs are registered. Decisions use the inputs present at a clock edge; the result is visible after that edge (latency 1).
- Output selection, evaluated in this priority order at each edge:
  1. valid_main = 1: data_out = main_in, valid_out = 1, src_out = 0. No FIFO pop.
  2. Else, FIFO not empty: data_out = FIFO head, pop, valid_out = 1, src_out = 1.
  3. Else, valid_recirc = 1 (FIFO empty): bypass. data_out = recirc_in, valid_out = 1, src_out = 1. The word is not written to the FIFO.
  4. Else: data_out = 0, valid_out = 0, src_out = 0.
- FIFO push: valid_recirc = 1 pushes the 4-lane word unless it was consumed by bypass (case 3).
- Push while the FIFO is full and no pop occurs in the same cycle:
  - the word is dropped and the FIFO is unchanged;
  - overflow is set to 1 and stays 1 until reset.
- Push and pop in the same cycle:
  - always allowed, including when the FIFO is full;
  - fifo_count is unchanged;
  - the popped word is the old head.
- Ordering: the FIFO is strictly first-in first-out. Returned words leave in arrival order. Bypass happens only when the FIFO is empty, so order is preserved.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- fifo_count, fifo_full and fifo_empty are registered and consistent with the same edge as the data.
- Lanes never mix: a word's 4 lanes always travel together.
- No backpressure: the downstream side must accept every valid_out cycle.

Test Plan:
- Reset release, no valid inputs for 5 cycles -> valid_out = 0, data_out0..3 = 0, fifo_empty = 1, fifo_count = 0, overflow = 0.
- valid_main = 1 with main_in = {8'h11, 8'h22, 8'h33, 8'h44}, valid_recirc = 0 -> on the next cycle data_out = 11/22/33/44, valid_out = 1, src_out = 0.
- valid_main = 0, FIFO empty, valid_recirc = 1 with recirc_in = A0..A3 -> next cycle data_out = A0..A3, src_out = 1, fifo_count stays 0 (bypass).
- valid_main = 1 for 3 cycles while recirc words R1, R2, R3 arrive, then valid_main = 0:
  - fifo_count steps 1, 2, 3 during the main burst;
  - then R1, R2, R3 are output in order with src_out = 1;
  - fifo_count goes back to 0.
- valid_main = 1 held while DEPTH+1 = 5 recirc words arrive -> fifo_full = 1 after the 4th, 5th word dropped, overflow = 1 and stays 1; after valid_main drops, exactly the first 4 words are output.
- FIFO holds 2 words and reset_L is pulsed low mid-stream -> outputs go to reset values immediately; after release fifo_count = 0 and the old words are never output.

Source files
------------

// File: rtl/recirc_merge.sv
// Merges the main 4-lane stream with words returning from the probador path.
// Main traffic wins; returned words queue in a small FIFO and fill idle cycles.
module recirc_merge #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] main_in0,
    input  logic [DATA_WIDTH-1:0] main_in1,
    input  logic [DATA_WIDTH-1:0] main_in2,
    input  logic [DATA_WIDTH-1:0] main_in3,
    input  logic                  valid_main,
    input  logic [DATA_WIDTH-1:0] recirc_in0,
    input  logic [DATA_WIDTH-1:0] recirc_in1,
    input  logic [DATA_WIDTH-1:0] recirc_in2,
    input  logic [DATA_WIDTH-1:0] recirc_in3,
    input  logic                  valid_recirc,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic [DATA_WIDTH-1:0] data_out3,
    output logic                  valid_out,
    output logic                  src_out,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = 4 * DATA_WIDTH;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [WORD_W-1:0] main_word;
    logic [WORD_W-1:0] recirc_word;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_src;
    logic              pop;
    logic              bypass;
    logic              push_req;
    logic              push;
    logic              drop;
    logic [CNT_W-1:0]  count_next;

    assign main_word   = {main_in0, main_in1, main_in2, main_in3};
    assign recirc_word = {recirc_in0, recirc_in1, recirc_in2, recirc_in3};

    // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        out_word  = '0;
        out_valid = 1'b0;
        out_src   = 1'b0;
        pop       = 1'b0;
        bypass    = 1'b0;
        if (valid_main) begin
            out_word  = main_word;
            out_valid = 1'b1;
        end else if (!fifo_empty) begin
            out_word  = mem[rd_ptr];
            out_valid = 1'b1;
            out_src   = 1'b1;
            pop       = 1'b1;
        end else if (valid_recirc) begin
            out_word  = recirc_word;
            out_valid = 1'b1;
            out_src   = 1'b1;
            bypass    = 1'b1;
        end
    end

    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push_req   = valid_recirc && !bypass;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out0  <= '0;
            data_out1  <= '0;
            data_out2  <= '0;
            data_out3  <= '0;
            valid_out  <= 1'b0;
            src_out    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            {data_out0, data_out1, data_out2, data_out3} <= out_word;
            valid_out  <= out_valid;
            src_out    <= out_src;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_next;
            fifo_full  <= (count_next == CNT_W'(DEPTH));
            fifo_empty <= (count_next == '0);
            if (drop) overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= recirc_word;
    end

endmodule

// File: tb/tb_recirc_merge.sv
// Directed bench for recirc_merge: priority, bypass, FIFO order, overflow, full push/pop, reset.
module tb_recirc_merge;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] main_in0, main_in1, main_in2, main_in3;
    logic [7:0] recirc_in0, recirc_in1, recirc_in2, recirc_in3;
    logic       valid_main, valid_recirc;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out, src_out;
    logic [2:0] fifo_count;
    logic       fifo_full, fifo_empty, overflow;
    logic [31:0] dout;

    int compared   = 0;
    int mismatched = 0;

    recirc_merge #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset_L(reset_L),
        .main_in0(main_in0), .main_in1(main_in1), .main_in2(main_in2), .main_in3(main_in3),
        .valid_main(valid_main),
        .recirc_in0(recirc_in0), .recirc_in1(recirc_in1), .recirc_in2(recirc_in2), .recirc_in3(recirc_in3),
        .valid_recirc(valid_recirc),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
        .valid_out(valid_out), .src_out(src_out),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow)
    );

    always #5 clk = ~clk;
    assign dout = {data_out0, data_out1, data_out2, data_out3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vm, input logic [31:0] mw, input logic vr, input logic [31:0] rw);
        valid_main = vm;
        {main_in0, main_in1, main_in2, main_in3} = mw;
        valid_recirc = vr;
        {recirc_in0, recirc_in1, recirc_in2, recirc_in3} = rw;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) tick();
        reset_L = 1'b1;
        repeat (5) tick();
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        compared++; if (dout !== 32'h0) begin mismatched++; $display("FAIL reset_data got %h exp 00000000", dout); end
        compared++; if (fifo_empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
        compared++; if (fifo_count !== 3'd0) begin mismatched++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        compared++; if (fifo_full !== 1'b0) begin mismatched++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    endtask

    task automatic test_main();
        drive(1'b1, 32'h11223344, 1'b0, 32'h0);
        tick();
        compared++; if (dout !== 32'h11223344) begin mismatched++; $display("FAIL main_data got %h exp 11223344", dout); end
        compared++; if (valid_out !== 1'b1) begin mismatched++; $display("FAIL main_valid got %b exp 1", valid_out); end
        compared++; if (src_out !== 1'b0) begin mismatched++; $display("FAIL main_src got %b exp 0", src_out); end
    endtask

    task automatic test_bypass();
        drive(1'b0, 32'h0, 1'b1, 32'hA0A1A2A3);
        tick();
        compared++; if (dout !== 32'hA0A1A2A3) begin mismatched++; $display("FAIL bypass_data got %h exp a0a1a2a3", dout); end
        compared++; if (src_out !== 1'b1 || valid_out !== 1'b1) begin mismatched++; $display("FAIL bypass_src_valid got %b%b exp 11", src_out, valid_out); end
        compared++; if (fifo_count !== 3'd0) begin mismatched++; $display("FAIL bypass_count got %0d exp 0", fifo_count); end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        compared++; if (valid_out !== 1'b0 || dout !== 32'h0) begin mismatched++; $display("FAIL idle_after_bypass got %b/%h exp 0/00000000", valid_out, dout); end
    endtask

    task automatic test_fifo_order();
        logic [31:0] r [3] = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0C0C0C0 + i, 1'b1, r[i]);
            tick();
            compared++; if (fifo_count !== 3'(i + 1)) begin mismatched++; $display("FAIL order_fill_count[%0d] got %0d exp %0d", i, fifo_count, i + 1); end
            compared++; if (dout !== 32'hC0C0C0C0 + i || src_out !== 1'b0) begin mismatched++; $display("FAIL order_main[%0d] got %h/%b exp %h/0", i, dout, src_out, 32'hC0C0C0C0 + i); end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (dout !== r[i] || src_out !== 1'b1 || valid_out !== 1'b1) begin mismatched++; $display("FAIL order_drain[%0d] got %h/%b/%b exp %h/1/1", i, dout, src_out, valid_out, r[i]); end
            compared++; if (fifo_count !== 3'(2 - i)) begin mismatched++; $display("FAIL order_drain_count[%0d] got %0d exp %0d", i, fifo_count, 2 - i); end
        end
        tick();
        compared++; if (valid_out !== 1'b0 || fifo_empty !== 1'b1) begin mismatched++; $display("FAIL order_done got %b/%b exp 0/1", valid_out, fifo_empty); end
    endtask

    task automatic test_overflow();
        logic [31:0] w [5] = '{32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040, 32'h50505050};
        int exp_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hEEEEEEEE, 1'b1, w[i]);
            tick();
            exp_cnt = (i < 4) ? i + 1 : 4;
            compared++; if (fifo_count !== 3'(exp_cnt)) begin mismatched++; $display("FAIL ovf_count[%0d] got %0d exp %0d", i, fifo_count, exp_cnt); end
            compared++; if (fifo_full !== (i >= 3)) begin mismatched++; $display("FAIL ovf_full[%0d] got %b exp %b", i, fifo_full, i >= 3); end
            compared++; if (overflow !== (i == 4)) begin mismatched++; $display("FAIL ovf_flag[%0d] got %b exp %b", i, overflow, i == 4); end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (dout !== w[i] || src_out !== 1'b1) begin mismatched++; $display("FAIL ovf_drain[%0d] got %h/%b exp %h/1", i, dout, src_out, w[i]); end
        end
        tick();
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL ovf_no_fifth got %b exp 0", valid_out); end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h77777777, 1'b1, 32'h61616161);
        tick();
        drive(1'b1, 32'h77777777, 1'b1, 32'h62626262);
        tick();
        compared++; if (fifo_count !== 3'd2 || valid_out !== 1'b1) begin mismatched++; $display("FAIL rstmid_pre got %0d/%b exp 2/1", fifo_count, valid_out); end
        #2 reset_L = 1'b0;
        #1;
        compared++; if (valid_out !== 1'b0 || dout !== 32'h0 || src_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_outputs got %b/%h/%b exp 0/00000000/0", valid_out, dout, src_out); end
        compared++; if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || overflow !== 1'b0) begin mismatched++; $display("FAIL rstmid_flags got %0d/%b/%b exp 0/1/0", fifo_count, fifo_empty, overflow); end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (valid_out !== 1'b0 || fifo_count !== 3'd0) begin mismatched++; $display("FAIL rstmid_lost[%0d] got %b/%0d exp 0/0", i, valid_out, fifo_count); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w [4] = '{32'h81818181, 32'h82828282, 32'h83838383, 32'h84848484};
        logic [31:0] exp_order [4] = '{32'h82828282, 32'h83838383, 32'h84848484, 32'h99999999};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h55555555, 1'b1, w[i]);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 32'h99999999);
        tick();
        compared++; if (dout !== w[0] || src_out !== 1'b1) begin mismatched++; $display("FAIL pushpop_head got %h/%b exp %h/1", dout, src_out, w[0]); end
        compared++; if (fifo_count !== 3'd4 || fifo_full !== 1'b1 || overflow !== 1'b0) begin mismatched++; $display("FAIL pushpop_state got %0d/%b/%b exp 4/1/0", fifo_count, fifo_full, overflow); end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (dout !== exp_order[i] || valid_out !== 1'b1) begin mismatched++; $display("FAIL pushpop_drain[%0d] got %h/%b exp %h/1", i, dout, valid_out, exp_order[i]); end
        end
        tick();
        compared++; if (fifo_empty !== 1'b1 || valid_out !== 1'b0) begin mismatched++; $display("FAIL pushpop_done got %b/%b exp 1/0", fifo_empty, valid_out); end
    endtask

    initial begin
        test_reset();
        test_main();
        test_bypass();
        test_fifo_order();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
